rv32i_cpu_core: RTL and testbench

//  Multi-cycle RV32I integer core subset (R-type ALU, I-type ALU, LW, SW, LUI) behind a single 32-bit memory bus.

---
 rtl/rv32i_cpu_core_if.sv | 24 ++
 rtl/rv32i_cpu_core.sv | 196 +++++++++++++++++++
 tb/tb_rv32i_cpu_core.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_cpu_core_if.sv
// Memory-bus bundle between the RV32I core (master) and the memory model (slave).
interface rv32i_cpu_core_if;
    logic [31:0] data_in_BUS;
    logic        bus_full;
    logic [31:0] data_out_BUS;
    logic [31:0] address_out;
    logic        instr_wait;

    modport master (
        input  data_in_BUS,
        input  bus_full,
        output data_out_BUS,
        output address_out,
        output instr_wait
    );

    modport slave (
        output data_in_BUS,
        output bus_full,
        input  data_out_BUS,
        input  address_out,
        input  instr_wait
    );
endinterface

// File: rtl/rv32i_cpu_core.sv
// Multi-cycle RV32I subset core (R/I ALU, LW, SW, LUI): FETCH -> EXEC -> [MEM] -> FETCH.
module rv32i_cpu_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    rv32i_cpu_core_if.master    bus,
    output logic [31:0]         result,
    output logic [31:0]         imm_32,
    output logic [31:0]         reg1,
    output logic [31:0]         reg2,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [4:0]          rd,
    output logic                memToReg_flipflop,
    output logic [31:0]         data_cpu_o,
    output logic [31:0]         write_address,
    output logic [31:0]         reg_write,
    output logic                reg_write_en
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, ir_q, result_q, data_cpu_q, write_address_q;
    logic              mem_to_reg_q;
    logic [XLEN-1:0]   rf_q [NREG];

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              is_r, is_i, is_lw, is_sw, is_lui;
    logic [XLEN-1:0]   alu_b, alu_out;
    logic [4:0]        shamt;

    logic              ir_load, pc_inc, exec_done, addr_load, load_capture;
    logic              wb_en;
    logic [XLEN-1:0]   wb_data;
    logic [XLEN-1:0]   addr_out_c, dout_c;
    logic              wait_c;

    // Instruction field decode and immediate selection from the latched IR
    always_comb begin
        opcode = ir_q[6:0];
        funct3 = ir_q[14:12];
        rs1    = ir_q[19:15];
        rs2    = ir_q[24:20];
        rd     = ir_q[11:7];
        is_r   = (opcode == OP_R);
        is_i   = (opcode == OP_I);
        is_lw  = (opcode == OP_LOAD)  && (funct3 == 3'b010);
        is_sw  = (opcode == OP_STORE) && (funct3 == 3'b010);
        is_lui = (opcode == OP_LUI);
        case (opcode)
            OP_STORE: imm_32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            OP_LUI:   imm_32 = {ir_q[31:12], 12'b0};
            OP_R:     imm_32 = '0;
            default:  imm_32 = {{20{ir_q[31]}}, ir_q[31:20]};
        endcase
        reg1 = rf_q[rs1];
        reg2 = rf_q[rs2];
    end

    // ALU: funct7[5] only matters for R-type ADD/SUB and for SRL/SRA
    always_comb begin
        alu_b   = is_r ? reg2 : imm_32;
        shamt   = alu_b[4:0];
        alu_out = '0;
        if (is_lui) begin
            alu_out = imm_32;
        end else if (is_lw || is_sw) begin
            alu_out = reg1 + imm_32;
        end else begin
            case (funct3)
                3'b000:  alu_out = (is_r && ir_q[30]) ? reg1 - alu_b : reg1 + alu_b;
                3'b001:  alu_out = reg1 << shamt;
                3'b010:  alu_out = XLEN'($signed(reg1) < $signed(alu_b));
                3'b011:  alu_out = XLEN'(reg1 < alu_b);
                3'b100:  alu_out = reg1 ^ alu_b;
                3'b101:  alu_out = ir_q[30] ? XLEN'($signed(reg1) >>> shamt) : (reg1 >> shamt);
                3'b110:  alu_out = reg1 | alu_b;
                3'b111:  alu_out = reg1 & alu_b;
                default: alu_out = '0;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // FSM next state, datapath strobes and bus outputs
    always_comb begin
        state_d      = state_q;
        ir_load      = 1'b0;
        pc_inc       = 1'b0;
        exec_done    = 1'b0;
        addr_load    = 1'b0;
        load_capture = 1'b0;
        wb_en        = 1'b0;
        wb_data      = '0;
        addr_out_c   = '0;
        dout_c       = '0;
        wait_c       = 1'b0;
        case (state_q)
            S_FETCH: begin
                wait_c     = 1'b1;
                addr_out_c = pc_q;
                if (bus.bus_full) begin
                    ir_load = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                exec_done = 1'b1;
                if (is_lw || is_sw) begin
                    addr_load = 1'b1;
                    state_d   = S_MEM;
                end else begin
                    pc_inc  = 1'b1;
                    state_d = S_FETCH;
                    if (is_r || is_i || is_lui) begin
                        wb_en   = 1'b1;
                        wb_data = alu_out;
                    end
                end
            end
            S_MEM: begin
                wait_c     = 1'b1;
                addr_out_c = write_address_q;
                if (is_sw) dout_c = reg2;
                if (bus.bus_full) begin
                    pc_inc  = 1'b1;
                    state_d = S_FETCH;
                    if (is_lw) begin
                        wb_en        = 1'b1;
                        wb_data      = bus.data_in_BUS;
                        load_capture = 1'b1;
                    end
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Architectural and holding registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q            <= RESET_PC;
            ir_q            <= '0;
            result_q        <= '0;
            data_cpu_q      <= '0;
            write_address_q <= '0;
            mem_to_reg_q    <= 1'b0;
        end else begin
            if (ir_load)      ir_q            <= bus.data_in_BUS;
            if (pc_inc)       pc_q            <= pc_q + 32'd4;
            if (addr_load)    write_address_q <= alu_out;
            if (load_capture) data_cpu_q      <= bus.data_in_BUS;
            if (exec_done) begin
                result_q     <= alu_out;
                mem_to_reg_q <= is_lw;
            end
        end
    end

    // Register file; x0 is never written so it reads as zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
        end else if (wb_en && (rd != 5'd0)) begin
            rf_q[rd] <= wb_data;
        end
    end

    assign result            = result_q;
    assign data_cpu_o        = data_cpu_q;
    assign write_address     = write_address_q;
    assign memToReg_flipflop = mem_to_reg_q;
    assign reg_write         = wb_data;
    assign reg_write_en      = wb_en;
    assign bus.address_out   = addr_out_c;
    assign bus.data_out_BUS  = dout_c;
    assign bus.instr_wait    = wait_c;

endmodule

// File: tb/tb_rv32i_cpu_core.sv
// Self-checking bench for rv32i_cpu_core: vector table plus write-back scoreboard.
module tb_rv32i_cpu_core;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv32i_cpu_core_if bus();

    logic [31:0] result, imm_32, reg1, reg2, data_cpu_o, write_address, reg_write;
    logic [4:0]  rs1, rs2, rd;
    logic        memToReg_flipflop, reg_write_en;

    rv32i_cpu_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus.master),
        .result            (result),
        .imm_32            (imm_32),
        .reg1              (reg1),
        .reg2              (reg2),
        .rs1               (rs1),
        .rs2               (rs2),
        .rd                (rd),
        .memToReg_flipflop (memToReg_flipflop),
        .data_cpu_o        (data_cpu_o),
        .write_address     (write_address),
        .reg_write         (reg_write),
        .reg_write_en      (reg_write_en)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard of expected register write-backs
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
    } wb_t;
    wb_t sb_q[$];

    task automatic sb_push(input logic [4:0] r, input logic [31:0] v);
        wb_t e;
        e.rd  = r;
        e.val = v;
        sb_q.push_back(e);
    endtask

    // Monitor: every write strobe must match the oldest expected write-back
    always @(negedge clk) begin
        wb_t e;
        if (!rst && reg_write_en) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb actual rd=%0d data=%h expected none", rd, reg_write);
            end else begin
                e = sb_q.pop_front();
                chk("wb_rd", 32'(rd), 32'(e.rd));
                chk("wb_data", reg_write, e.val);
            end
        end
    end

    // Instruction encoders
    function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [4:0] b, input logic [4:0] a,
                                         input logic [2:0] f3, input logic [4:0] d);
        return {f7, b, a, f3, d, 7'b0110011};
    endfunction
    function automatic logic [31:0] i_op(input logic [11:0] imm, input logic [4:0] a,
                                         input logic [2:0] f3, input logic [4:0] d);
        return {imm, a, f3, d, 7'b0010011};
    endfunction
    function automatic logic [31:0] lw_op(input logic [11:0] imm, input logic [4:0] a, input logic [4:0] d);
        return {imm, a, 3'b010, d, 7'b0000011};
    endfunction
    function automatic logic [31:0] sw_op(input logic [11:0] imm, input logic [4:0] b, input logic [4:0] a);
        return {imm[11:5], b, a, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] lui_op(input logic [19:0] imm, input logic [4:0] d);
        return {imm, d, 7'b0110111};
    endfunction

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] data;
        bit          is_load;
        bit          wb;
        logic [31:0] wval;
        bit          chk_res;
        logic [31:0] res;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input string n, input logic [31:0] ins, input logic [31:0] d, input bit ld,
                           input bit w, input logic [31:0] wv, input bit cr, input logic [31:0] r);
        vec_t v;
        v.name = n; v.instr = ins; v.data = d; v.is_load = ld;
        v.wb = w; v.wval = wv; v.chk_res = cr; v.res = r;
        vecs.push_back(v);
    endtask

    // Wait (bounded) until the core asks for a bus word, then check the fetch address
    task automatic wait_fetch();
        int n = 0;
        while (!bus.instr_wait && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.instr_wait) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout actual instr_wait=0 expected 1");
        end
        chk("fetch_pc", bus.address_out, exp_pc);
    endtask

    task automatic strobe(input logic [31:0] word);
        bus.bus_full    = 1'b1;
        bus.data_in_BUS = word;
        @(posedge clk); #1;
        bus.bus_full    = 1'b0;
        bus.data_in_BUS = '0;
    endtask

    task automatic run_vec(input vec_t v);
        if (v.wb && !v.is_load) sb_push(v.instr[11:7], v.wval);
        wait_fetch();
        strobe(v.instr);
        @(posedge clk); #1;
        if (v.chk_res) chk({v.name, "_result"}, result, v.res);
        if (v.is_load) begin
            chk({v.name, "_memwait"}, 32'(bus.instr_wait), 32'd1);
            chk({v.name, "_memtoreg"}, 32'(memToReg_flipflop), 32'd1);
            if (v.wb) sb_push(v.instr[11:7], v.wval);
            strobe(v.data);
            chk({v.name, "_data_cpu"}, data_cpu_o, v.data);
        end
        exp_pc = exp_pc + 32'd4;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_result"}, result, 32'd0);
        chk({tag, "_addr"}, bus.address_out, 32'd0);
        chk({tag, "_dout"}, bus.data_out_BUS, 32'd0);
        chk({tag, "_reg1"}, reg1, 32'd0);
        chk({tag, "_imm"}, imm_32, 32'd0);
        chk({tag, "_data_cpu"}, data_cpu_o, 32'd0);
        chk({tag, "_waddr"}, write_address, 32'd0);
        chk({tag, "_memtoreg"}, 32'(memToReg_flipflop), 32'd0);
        chk({tag, "_wb_en"}, 32'(reg_write_en), 32'd0);
        chk({tag, "_fetch_wait"}, 32'(bus.instr_wait), 32'd1);
    endtask

    initial begin
        vec_t v;
        rst             = 1'b1;
        bus.bus_full    = 1'b0;
        bus.data_in_BUS = '0;
        exp_pc          = 32'd0;

        add_vec("lw_x1_a",  lw_op(12'd3, 5'd4, 5'd1), 32'd1,  1, 1, 32'd1,  1, 32'd3);
        add_vec("lw_x2_a",  lw_op(12'd3, 5'd4, 5'd2), 32'd1,  1, 1, 32'd1,  1, 32'd3);
        add_vec("add_1_1",  r_op(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 0, 0, 1, 32'd2, 1, 32'd2);
        add_vec("lw_x1_b",  lw_op(12'd3, 5'd4, 5'd1), 32'd32, 1, 1, 32'd32, 1, 32'd3);
        add_vec("lw_x2_b",  lw_op(12'd3, 5'd4, 5'd2), 32'd2,  1, 1, 32'd2,  1, 32'd3);
        add_vec("sub_32_2", r_op(7'h20, 5'd2, 5'd1, 3'b000, 5'd3), 0, 0, 1, 32'd30, 1, 32'd30);
        add_vec("lui_x5",   lui_op(20'h00010, 5'd5), 0, 0, 1, 32'h0001_0000, 1, 32'h0001_0000);
        add_vec("addi_m1",  i_op(12'hFFF, 5'd5, 3'b000, 5'd5), 0, 0, 1, 32'h0000_FFFF, 1, 32'h0000_FFFF);
        add_vec("lui_x6",   lui_op(20'hFFFF0, 5'd6), 0, 0, 1, 32'hFFFF_0000, 1, 32'hFFFF_0000);
        add_vec("add_wrap", r_op(7'h00, 5'd6, 5'd5, 3'b000, 5'd7), 0, 0, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF);
        add_vec("sub_wrap", r_op(7'h20, 5'd6, 5'd7, 3'b000, 5'd8), 0, 0, 1, 32'h0000_FFFF, 1, 32'h0000_FFFF);
        add_vec("addi_one", i_op(12'h001, 5'd0, 3'b000, 5'd9), 0, 0, 1, 32'd1, 1, 32'd1);
        add_vec("xor_1_1",  r_op(7'h20, 5'd9, 5'd9, 3'b100, 5'd10), 0, 0, 1, 32'd0, 1, 32'd0);
        add_vec("xor_1_0",  r_op(7'h20, 5'd0, 5'd9, 3'b100, 5'd11), 0, 0, 1, 32'd1, 1, 32'd1);
        add_vec("or_1_0",   r_op(7'h20, 5'd0, 5'd9, 3'b110, 5'd12), 0, 0, 1, 32'd1, 1, 32'd1);
        add_vec("or_0_0",   r_op(7'h20, 5'd0, 5'd0, 3'b110, 5'd13), 0, 0, 1, 32'd0, 1, 32'd0);
        add_vec("and_1_1",  r_op(7'h20, 5'd9, 5'd9, 3'b111, 5'd14), 0, 0, 1, 32'd1, 1, 32'd1);
        add_vec("and_1_0",  r_op(7'h20, 5'd0, 5'd9, 3'b111, 5'd15), 0, 0, 1, 32'd0, 1, 32'd0);
        add_vec("slt_neg",  r_op(7'h00, 5'd9, 5'd7, 3'b010, 5'd16), 0, 0, 1, 32'd1, 1, 32'd1);
        add_vec("sltu_max", r_op(7'h00, 5'd9, 5'd7, 3'b011, 5'd17), 0, 0, 1, 32'd0, 1, 32'd0);
        add_vec("sra_1",    r_op(7'h20, 5'd9, 5'd6, 3'b101, 5'd18), 0, 0, 1, 32'hFFFF_8000, 1, 32'hFFFF_8000);
        add_vec("srl_1",    r_op(7'h00, 5'd9, 5'd6, 3'b101, 5'd19), 0, 0, 1, 32'h7FFF_8000, 1, 32'h7FFF_8000);
        add_vec("srai_4",   i_op(12'h404, 5'd6, 3'b101, 5'd20), 0, 0, 1, 32'hFFFF_F000, 1, 32'hFFFF_F000);
        add_vec("slli_31",  i_op(12'h01F, 5'd9, 3'b001, 5'd21), 0, 0, 1, 32'h8000_0000, 1, 32'h8000_0000);
        add_vec("sll_reg",  r_op(7'h00, 5'd7, 5'd9, 3'b001, 5'd22), 0, 0, 1, 32'h8000_0000, 1, 32'h8000_0000);
        add_vec("addi_x0",  i_op(12'h005, 5'd9, 3'b000, 5'd0), 0, 0, 1, 32'd6, 1, 32'd6);
        add_vec("x0_zero",  r_op(7'h00, 5'd9, 5'd0, 3'b000, 5'd23), 0, 0, 1, 32'd1, 1, 32'd1);
        add_vec("nop_op",   32'h0000_0F7F, 0, 0, 0, 32'd0, 0, 32'd0);
        add_vec("lb_nop",   {12'd0, 5'd9, 3'b000, 5'd24, 7'b0000011}, 0, 0, 0, 32'd0, 0, 32'd0);
        add_vec("slti",     i_op(12'h001, 5'd7, 3'b010, 5'd25), 0, 0, 1, 32'd1, 1, 32'd1);
        add_vec("sltiu",    i_op(12'hFFF, 5'd9, 3'b011, 5'd26), 0, 0, 1, 32'd1, 1, 32'd1);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_zero_outputs("reset");

        foreach (vecs[i]) run_vec(vecs[i]);

        // Store after the sub: x3=30, x2=2 -> address 0x63
        wait_fetch();
        strobe(sw_op(12'h061, 5'd3, 5'd2));
        @(posedge clk); #1;
        chk("sw_result", result, 32'h63);
        chk("sw_imm", imm_32, 32'h61);
        chk("sw_wait", 32'(bus.instr_wait), 32'd1);
        chk("sw_addr", bus.address_out, 32'h63);
        chk("sw_dout", bus.data_out_BUS, 32'd30);
        chk("sw_waddr", write_address, 32'h63);
        @(posedge clk); #1;
        chk("sw_hold_addr", bus.address_out, 32'h63);
        chk("sw_hold_dout", bus.data_out_BUS, 32'd30);
        strobe(32'hDEAD_BEEF);
        chk("sw_done_dout", bus.data_out_BUS, 32'd0);
        exp_pc = exp_pc + 32'd4;

        // Reset while a load sits in MEM
        wait_fetch();
        strobe(lw_op(12'd0, 5'd9, 5'd1));
        @(posedge clk); #1;
        chk("rstmem_in_mem_addr", bus.address_out, 32'd1);
        #2 rst = 1'b1;
        #1 chk_zero_outputs("rst_mem");
        @(posedge clk); #1 rst = 1'b0;
        exp_pc = 32'd0;
        v.name = "post_rst"; v.instr = r_op(7'h00, 5'd8, 5'd7, 3'b000, 5'd23); v.data = 0;
        v.is_load = 0; v.wb = 1; v.wval = 32'd0; v.chk_res = 1; v.res = 32'd0;
        run_vec(v);
        v.name = "post_rst_or"; v.instr = r_op(7'h00, 5'd6, 5'd9, 3'b110, 5'd24); v.wval = 32'd0; v.res = 32'd0;
        run_vec(v);

        wait_fetch();
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net against a stuck simulation
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
